// File: rtl/moore_seq_if.sv
// ----------------------------------------------------------------------------
// moore_seq_if
// Serial data / detect-flag bundle for the moore_seq run detector.
//
// Signals:
//   x  serial data bit, one sample per rising clk edge (source -> detector)
//   y  run-of-three flag (detector -> consumer)
//
// Modports:
//   master  stream source / flag consumer: drives x, observes y
//   slave   detector side: observes x, drives y
// ----------------------------------------------------------------------------
interface moore_seq_if;
    logic x;
    logic y;

    modport master (
        output x,
        input  y
    );

    modport slave (
        input  x,
        output y
    );
endinterface : moore_seq_if

// File: rtl/moore_seq.sv
// ----------------------------------------------------------------------------
// moore_seq
// Moore-type detector for a run of three identical bits on a serial stream.
// The flag is high while the three most recent samples taken since reset are
// all 1 or all 0. Overlapping runs keep it high. The flag is decoded only from
// the state register and never looks at the current input bit.
//
// Ports:
//   clk  system clock; state changes on its rising edge
//   rst  synchronous active-high reset; takes priority over the data bit
//   sif  moore_seq_if.slave: sif.x serial bit in, sif.y detect flag out
// ----------------------------------------------------------------------------
module moore_seq (
    input  logic              clk,
    input  logic              rst,
    moore_seq_if.slave        sif
);

    // One state per run length for each polarity. The 3-bit code 3'b111 is
    // left unused and falls back to IDLE through the default branch.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ONE1  = 3'd1,
        ONE2  = 3'd2,
        ONE3  = 3'd3,
        ZERO1 = 3'd4,
        ZERO2 = 3'd5,
        ZERO3 = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_y;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode.
    // A changed bit always restarts the opposite run at length 1, so every
    // state on x=1 goes either deeper into the 1-run or back to ONE1, and
    // likewise for x=0.
    always_comb begin
        w_state_nxt = IDLE;
        w_y         = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = sif.x ? ONE1 : ZERO1;
            end
            ONE1: begin
                w_state_nxt = sif.x ? ONE2 : ZERO1;
            end
            ONE2: begin
                w_state_nxt = sif.x ? ONE3 : ZERO1;
            end
            ONE3: begin
                w_state_nxt = sif.x ? ONE3 : ZERO1;
                w_y         = 1'b1;
            end
            ZERO1: begin
                w_state_nxt = sif.x ? ONE1 : ZERO2;
            end
            ZERO2: begin
                w_state_nxt = sif.x ? ONE1 : ZERO3;
            end
            ZERO3: begin
                w_state_nxt = sif.x ? ONE1 : ZERO3;
                w_y         = 1'b1;
            end
            default: begin
                // Unused encoding: recover to IDLE with the flag low.
                w_state_nxt = IDLE;
                w_y         = 1'b0;
            end
        endcase
    end

    // The flag is set in the case arms only from the state, so it has no
    // combinational dependence on sif.x.
    assign sif.y = w_y;

endmodule : moore_seq

// File: tb/tb_moore_seq.sv
// ----------------------------------------------------------------------------
// tb_moore_seq
// Self-checking bench for moore_seq. A table of {rst, x, expected y} records
// is applied one clock edge per record and y is compared 1 ns after each
// edge. Hand-written sequences follow for reset in the middle of a run and
// for the flag holding steady while x changes between edges.
// ----------------------------------------------------------------------------
module tb_moore_seq;

    logic clk;
    logic rst;

    moore_seq_if sif ();

    moore_seq dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic x;
        logic exp_y;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    task automatic add(input logic r, input logic xv, input logic ey);
        vec_t v;
        v.rst   = r;
        v.x     = xv;
        v.exp_y = ey;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic ey);
        n_tests++;
        if (sif.y !== ey) begin
            n_fail++;
            $display("FAIL %s[%0d]: y=%b expected %b", name, idx, sif.y, ey);
        end
    endtask

    // Drive inputs, take one rising edge, then compare 1 ns after it.
    task automatic step(input string name, input int idx,
                        input logic r, input logic xv, input logic ey);
        rst   = r;
        sif.x = xv;
        @(posedge clk);
        #1;
        check(name, idx, ey);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        sif.x   = 1'b0;

        // Reset, then x=0 twice: y stays low.
        add(1, 0, 0);
        add(0, 0, 0);
        add(0, 0, 0);
        // Run of 1s: 0,0,1,1 then a 0 drops it.
        add(1, 0, 0);
        add(0, 1, 0);
        add(0, 1, 0);
        add(0, 1, 1);
        add(0, 1, 1);
        add(0, 0, 0);
        // Run of 0s then two 1s.
        add(1, 0, 0);
        add(0, 0, 0);
        add(0, 0, 0);
        add(0, 0, 1);
        add(0, 0, 1);
        add(0, 1, 0);
        add(0, 1, 0);
        // Direct 111 -> 000 switchover.
        add(1, 0, 0);
        add(0, 1, 0);
        add(0, 1, 0);
        add(0, 1, 1);
        add(0, 0, 0);
        add(0, 0, 0);
        add(0, 0, 1);
        // 000 -> 111 switchover continuing from ZERO3.
        add(0, 1, 0);
        add(0, 1, 0);
        add(0, 1, 1);
        // Alternating bits never assert.
        add(1, 0, 0);
        add(0, 1, 0);
        add(0, 0, 0);
        add(0, 1, 0);
        add(0, 0, 0);
        add(0, 1, 0);
        add(0, 0, 0);
        // Reset has priority over a 1 arriving in ONE3.
        add(1, 0, 0);
        add(0, 1, 0);
        add(0, 1, 0);
        add(0, 1, 1);
        add(1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step("vec", i, vecs[i].rst, vecs[i].x, vecs[i].exp_y);
        end

        // After reset mid-run, the next 1 is ONE1: two more 1s needed.
        step("rst_midrun", 0, 0, 1, 0);
        step("rst_midrun", 1, 0, 1, 0);
        step("rst_midrun", 2, 0, 1, 1);

        // Flag must not follow x between edges (Moore output).
        sif.x = 1'b0;
        #2;
        check("no_comb_x", 0, 1'b1);
        step("no_comb_x", 1, 0, 0, 0);
        sif.x = 1'b1;
        #2;
        check("no_comb_x", 2, 1'b0);

        // Long run of 0s keeps the flag high every edge after the third.
        step("long_zero", 0, 0, 0, 0);
        step("long_zero", 1, 0, 0, 1);
        for (int k = 2; k < 8; k++) begin
            step("long_zero", k, 0, 0, 1);
        end
        step("long_zero", 8, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_moore_seq
